lsu_bram_port: RTL and testbench

- Load/store initiator that drives the read/write byte-enable port (port B) of the data-side true-dual-port BRAM.
- Accepts one RISC-V load or store request at a time from the core pipeline over a valid/ready handshake.
- Generates the word address, byte write enables and replicated store data for the memory port.
- Extracts and sign/zero-extends load data from the BRAM's registered read-first output (1-cycle read latency) and returns it over a response strobe.

---
 rtl/lsu_bram_port.sv | 98 +++++++++
 tb/tb_lsu_bram_port.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_bram_port.sv
// lsu_bram_port: single-outstanding RV32 load/store initiator for a read-first BRAM byte-enable port.
module lsu_bram_port #(
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_COL = 4,
  parameter int COL_WIDTH = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic accept, err, bad_f3, misaligned, out_of_range;
  logic [NUM_COL-1:0] we_mask;
  logic [DATA_WIDTH-1:0] din_rep;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign bad_f3 = req_we ? req_funct3 > 3'd2 : req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7;
  assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
  assign err = bad_f3 || misaligned || out_of_range;
  assign we_mask = req_funct3[1] ? 4'b1111 : req_funct3[0] ? 4'b0011 << req_addr[1:0] : 4'b0001 << req_addr[1:0];
  assign din_rep = req_funct3[1] ? req_wdata : req_funct3[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  assign byte_sel = mem_dout[{off_q, 3'b000} +: 8];
  assign half_sel = mem_dout[{off_q[1], 4'b0000} +: 16];
  // Stores respond with zero; the read-first word seen during a store is discarded.
  assign load_data = we_q ? 32'd0 :
                     f3_q == 3'd0 ? {{24{byte_sel[7]}}, byte_sel} :
                     f3_q == 3'd4 ? {24'd0, byte_sel} :
                     f3_q == 3'd1 ? {{16{half_sel[15]}}, half_sel} :
                     f3_q == 3'd5 ? {16'd0, half_sel} : mem_dout;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (accept ? (err ? RESP : ACCESS) : IDLE) :
                state == ACCESS ? WAIT :
                state == WAIT ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      off_q <= 2'd0;
      mem_en <= 1'b0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      mem_en <= 1'b0;
      mem_we <= '0;
      resp_valid <= 1'b0;
      if (accept) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        off_q <= req_addr[1:0];
        if (err) begin
          resp_valid <= 1'b1;
          resp_err <= 1'b1;
          resp_rdata <= 32'd0;
        end else begin
          mem_en <= 1'b1;
          mem_addr <= req_addr[ADDR_WIDTH+1:2];
          mem_we <= req_we ? we_mask : '0;
          if (req_we) mem_din <= din_rep;
        end
      end
      if (state == WAIT) begin
        resp_valid <= 1'b1;
        resp_err <= 1'b0;
        resp_rdata <= load_data;
      end
    end
  end
endmodule

// File: tb/tb_lsu_bram_port.sv
// tb_lsu_bram_port: scoreboard bench for lsu_bram_port with a read-first BRAM model and a reference memory.
module tb_lsu_bram_port;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic resp_valid, resp_err, mem_en;
  logic [31:0] resp_rdata, mem_din, mem_dout;
  logic [3:0] mem_we;
  logic [14:0] mem_addr;

  lsu_bram_port dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:32767];
  always @(posedge clk)
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      for (int i = 0; i < 4; i++) if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
    end

  typedef struct { logic err; logic [31:0] rdata; int cyc; } exp_t;
  exp_t sb[$];
  logic [31:0] ref_mem [int];
  int n_tests = 0, n_fail = 0, cyc = 0, en_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd);
    logic [31:0] w, sh;
    int sz, b;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    err = we ? f3 > 3'd2 : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (a % sz != 0) err = 1'b1;
    if (a >= 32'h0002_0000) err = 1'b1;
    rd = 32'd0;
    if (err) return;
    w = ref_mem.exists(int'(a[16:2])) ? ref_mem[int'(a[16:2])] : 32'd0;
    if (we) begin
      for (int i = 0; i < sz; i++) begin
        b = int'(a[1:0]) + i;
        w[8*b +: 8] = wd[8*i +: 8];
      end
      ref_mem[int'(a[16:2])] = w;
    end else begin
      sh = w >> (8 * a[1:0]);
      case (f3)
        3'd0: rd = {{24{sh[7]}}, sh[7:0]};
        3'd4: rd = {24'd0, sh[7:0]};
        3'd1: rd = {{16{sh[15]}}, sh[15:0]};
        3'd5: rd = {16'd0, sh[15:0]};
        default: rd = w;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input bit hold, input bit push, output int waits, output int acc);
    bit e;
    logic [31:0] rd;
    exp_t x;
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && waits < 20) begin @(negedge clk); waits++; end
    if (waits >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) req_valid = 1'b0;
    if (push) begin
      model(we, f3, a, wd, e, rd);
      x.err = e; x.rdata = rd; x.cyc = e ? acc : acc + 2;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, a1, a2, en0;
    for (int i = 0; i < 32768; i++) ram[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    send(1, 3'd2, 32'h40, 32'hDEADBEEF, 0, 1, w, a1);
    chk("sw_mem_en", {31'd0, mem_en}, 32'd1);
    chk("sw_mem_we", {28'd0, mem_we}, 32'hF);
    chk("sw_mem_addr", {17'd0, mem_addr}, 32'h10);
    chk("sw_mem_din", mem_din, 32'hDEADBEEF);
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    send(0, 3'd2, 32'h40, 32'd0, 0, 1, w, a1);
    send(1, 3'd0, 32'h43, 32'h000000A5, 0, 1, w, a1);
    chk("sb_mem_we", {28'd0, mem_we}, 32'h8);
    chk("sb_mem_din", mem_din, 32'hA5A5A5A5);
    send(0, 3'd2, 32'h40, 32'd0, 0, 1, w, a1);
    send(1, 3'd2, 32'h40, 32'h12348056, 0, 1, w, a1);
    send(0, 3'd0, 32'h41, 32'd0, 0, 1, w, a1);
    send(0, 3'd4, 32'h41, 32'd0, 0, 1, w, a1);
    send(0, 3'd1, 32'h42, 32'd0, 0, 1, w, a1);
    send(0, 3'd5, 32'h40, 32'd0, 0, 1, w, a1);
    drain();

    en0 = en_cnt;
    send(0, 3'd1, 32'h41, 32'd0, 0, 1, w, a1);
    send(1, 3'd2, 32'h42, 32'h11111111, 0, 1, w, a1);
    send(0, 3'd3, 32'h40, 32'd0, 0, 1, w, a1);
    send(0, 3'd2, 32'h0002_0000, 32'd0, 0, 1, w, a1);
    send(1, 3'd5, 32'h40, 32'd0, 0, 1, w, a1);
    drain();
    chk("err_no_mem_en", 32'(en_cnt - en0), 32'd0);

    send(0, 3'd2, 32'h40, 32'd0, 1, 1, w, a1);
    send(0, 3'd4, 32'h42, 32'd0, 0, 1, w, a2);
    chk("b2b_ready_low_cycles", 32'(w), 32'd3);
    chk("b2b_spacing", 32'(a2 - a1), 32'd4);
    drain();

    for (int i = 0; i < 30; i++)
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 15)),
           $urandom, 0, 1, w, a1);
    drain();

    send(0, 3'd2, 32'h40, 32'd0, 0, 0, w, a1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_resp_rdata", resp_rdata, 32'd0);
    chk("rstw_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rstw_mem_addr", {17'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);

    send(1, 3'd2, 32'h80, 32'hCAFEF00D, 0, 0, w, a1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[32'h80 >> 2] = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    send(0, 3'd2, 32'h80, 32'd0, 0, 1, w, a1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
